// File: rtl/stage_if_prefetch.sv
// Instruction fetch stage: one outstanding memory request feeding a DEPTH-entry prefetch queue.
// Latency: memAck to valid is one edge; request issue is one edge after IDLE with free space.
// Backpressure: freeze holds the head; fetching stops only when the queue is full.
module stage_if_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchAddr,
    input  logic              freeze,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic [INST_W-1:0] memData,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [INST_W-1:0] instruction
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] inst;
    } entry_t;

    state_t            state;
    logic [ADDR_W-1:0] fetchPc;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;
    entry_t            queue [DEPTH];

    logic   hasSpace;
    logic   doPush;
    logic   doPop;
    entry_t head;

    // A branch wins over both queue operations; only an ack for a live request pushes.
    assign hasSpace = (count < CNT_W'(DEPTH));
    assign doPush   = (state == WAIT) && memAck && !branchTaken;
    assign doPop    = valid && !freeze && !branchTaken;

    assign head        = queue[rdPtr];
    assign valid       = (count != '0);
    assign pc          = valid ? head.addr : '0;
    assign instruction = valid ? head.inst : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            memReq  <= 1'b0;
            memAddr <= '0;
            fetchPc <= RESET_PC;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!branchTaken && hasSpace) begin
                        memReq  <= 1'b1;
                        memAddr <= fetchPc;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (memAck) begin
                        memReq <= 1'b0;
                        state  <= IDLE;
                    end else if (branchTaken) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (memAck) begin
                        memReq <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    memReq <= 1'b0;
                    state  <= IDLE;
                end
            endcase

            if (branchTaken) begin
                fetchPc <= branchAddr;
                rdPtr   <= '0;
                wrPtr   <= '0;
                count   <= '0;
            end else begin
                if (doPush) begin
                    wrPtr   <= wrPtr + PTR_W'(1);
                    fetchPc <= fetchPc + ADDR_W'(PC_STEP);
                end
                if (doPop) begin
                    rdPtr <= rdPtr + PTR_W'(1);
                end
                case ({doPush, doPop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue storage carries no reset; count gates everything read from it.
    always_ff @(posedge clk) begin
        if (doPush) begin
            queue[wrPtr] <= '{addr: fetchPc, inst: memData};
        end
    end

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Bench for stage_if_prefetch: directed scenarios plus random traffic against a queue-level model.
module tb_stage_if_prefetch;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] RPC     = 32'h0000_0000;
    localparam int          PC_STEP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branchTaken = 1'b0;
    logic [31:0] branchAddr = '0;
    logic        freeze = 1'b0;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck = 1'b0;
    logic [31:0] memData = '0;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instruction;

    always #5 clk = ~clk;

    stage_if_prefetch #(
        .ADDR_W  (32),
        .INST_W  (32),
        .DEPTH   (DEPTH),
        .RESET_PC(RPC),
        .PC_STEP (PC_STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .branchTaken(branchTaken),
        .branchAddr (branchAddr),
        .freeze     (freeze),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memAck     (memAck),
        .memData    (memData),
        .valid      (valid),
        .pc         (pc),
        .instruction(instruction)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    // Reference: expected queue contents, whether a request is outstanding, and whether it was orphaned.
    ent_t        mq[$];
    logic        mOut   = 1'b0;
    logic        mStale = 1'b0;
    logic [31:0] mFetch = RPC;
    logic [31:0] mAddr  = '0;
    bit          chkEn  = 1'b0;
    bit          inRst  = 1'b0;

    int age   = 0;
    int lat   = 2;
    int latLo = 2;
    int latHi = 2;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] memHash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutputs();
        chk("memReq", {31'b0, memReq}, {31'b0, mOut});
        if (mOut) chk("memAddr", memAddr, mAddr);
        chk("valid", {31'b0, valid}, {31'b0, (mq.size() != 0)});
        if (mq.size() != 0) begin
            chk("pc", pc, mq[0].a);
            chk("instruction", instruction, mq[0].d);
        end else begin
            chk("instruction_idle", instruction, 32'h0);
        end
        if (inRst) chk("pc_reset", pc, 32'h0);
    endtask

    // One clock: check settled outputs, drive inputs and memory response, then advance the model.
    task automatic cycle(input logic r, input logic br, input logic [31:0] ba,
                         input logic frz, input logic fAck);
        logic        reqObs;
        logic        ack;
        logic [31:0] d;
        bit          doPop;
        bit          doPush;
        bit          doIssue;
        @(negedge clk);
        if (chkEn) checkOutputs();
        reqObs = (memReq === 1'b1);
        ack    = fAck | (reqObs && (age + 1 >= lat));
        d      = memHash(memAddr);
        rst         = r;
        branchTaken = br;
        branchAddr  = ba;
        freeze      = frz;
        memAck      = ack;
        memData     = d;
        @(posedge clk);
        if (!r) begin
            mq.delete();
            mOut   = 1'b0;
            mStale = 1'b0;
            mFetch = RPC;
            inRst  = 1'b1;
        end else begin
            inRst   = 1'b0;
            doPop   = !br && !frz && (mq.size() != 0);
            doIssue = !mOut && !br && (mq.size() < DEPTH);
            doPush  = mOut && ack && !mStale && !br;
            if (doPop) void'(mq.pop_front());
            if (doPush) begin
                mq.push_back('{a: mFetch, d: d});
                mFetch = mFetch + PC_STEP;
            end
            if (mOut && ack) begin
                mOut   = 1'b0;
                mStale = 1'b0;
            end else if (mOut && br) begin
                mStale = 1'b1;
            end
            if (br) begin
                mq.delete();
                mFetch = ba;
            end
            if (doIssue) begin
                mOut  = 1'b1;
                mAddr = mFetch;
            end
        end
        if (reqObs && ack) begin
            age = 0;
            lat = $urandom_range(latHi, latLo);
        end else if (reqObs) begin
            age++;
        end else begin
            age = 0;
        end
        chkEn = 1'b1;
    endtask

    task automatic setLat(input int lo, input int hi);
        latLo = lo;
        latHi = hi;
        lat   = $urandom_range(hi, lo);
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic run(input int n, input logic frz);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, frz, 1'b0);
    endtask

    initial begin
        bit found;

        // Streaming with a two-cycle memory, no stall.
        setLat(2, 2);
        doReset(3);
        run(24, 1'b0);

        // Held freeze fills the queue and stops fetching; release drains and resumes.
        setLat(1, 1);
        doReset(2);
        run(16, 1'b1);
        chk("full_no_req", {31'b0, memReq}, 32'h0);
        run(14, 1'b0);

        // Branch while the request to 0x8 is in flight.
        setLat(3, 3);
        doReset(2);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mOut && mAddr == 32'h8 && age == 0) begin
                cycle(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
                found = 1'b1;
            end else begin
                cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            end
        end
        chk("branch_inflight_found", {31'b0, found}, 32'h1);
        run(16, 1'b0);

        // Branch in the same cycle as an ack and a pop.
        setLat(2, 2);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (mOut && !mStale && (age + 1 >= lat) && mq.size() != 0) begin
                cycle(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
                found = 1'b1;
            end else begin
                cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            end
        end
        chk("branch_ack_pop_found", {31'b0, found}, 32'h1);
        chk("branch_ack_pop_empty", {31'b0, (mq.size() == 0)}, 32'h1);
        run(12, 1'b0);

        // Reset during a slow request, stray ack in the release cycle.
        setLat(5, 5);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mOut) found = 1'b1;
            cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        end
        chk("reset_wait_found", {31'b0, found}, 32'h1);
        doReset(2);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("post_reset_req_addr", mAddr, RPC);
        run(14, 1'b0);

        // Fetch address wraps past the top of the address space.
        setLat(1, 2);
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        run(14, 1'b0);

        // Random traffic: latency, freeze, branches and occasional resets.
        setLat(1, 4);
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom & 32'hFFFF_FFFC),
                  ($urandom_range(0, 9) < 3),
                  1'b0);
        end
        run(4, 1'b0);
        @(negedge clk);
        checkOutputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
